// File: rtl/deposit_money_module.sv
// deposit_money_module: customer deposit intake with headroom check, cash-store credit handshake and log strobe.
// Optional DEPOSIT_TIMEOUT_EN bounds the wait for cash_inc_ack to TIMEOUT_CYCLES CREDIT cycles.
module deposit_money_module #(
  parameter int AMOUNT_W       = 4,
  parameter int CASH_W         = 8,
  parameter int CASH_MAX       = 255,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                dep_valid,
  input  logic [AMOUNT_W-1:0] dep_amount,
  output logic                dep_ready,
  input  logic [CASH_W-1:0]   cash_value,
  output logic                cash_inc_valid,
  output logic [AMOUNT_W-1:0] cash_inc_amount,
  input  logic                cash_inc_ack,
  output logic                log_valid,
  output logic [1:0]          log_op,
  output logic                log_status,
  output logic [AMOUNT_W-1:0] log_amount,
  output logic                done,
  output logic                DP
);
  typedef enum logic [1:0] {IDLE, CHECK, CREDIT, LOG} state_e;
  state_e              state_q;
  logic [AMOUNT_W-1:0] amt_q;
  logic                st_q;
  logic                dp_q;
  logic [CASH_W:0]     sum;
  logic                reject;
`ifdef DEPOSIT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
`endif
  // one extra bit keeps the headroom compare from wrapping
  assign sum             = {1'b0, cash_value} + (CASH_W+1)'(amt_q);
  assign reject          = (amt_q == '0) || (sum > (CASH_W+1)'(CASH_MAX));
  assign dep_ready       = state_q == IDLE;
  assign cash_inc_valid  = state_q == CREDIT;
  assign cash_inc_amount = amt_q;
  assign log_valid       = state_q == LOG;
  assign done            = state_q == LOG;
  assign log_op          = 2'b01;
  assign log_status      = st_q;
  assign log_amount      = amt_q;
  assign DP              = dp_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      amt_q   <= '0;
      st_q    <= 1'b0;
      dp_q    <= 1'b0;
`ifdef DEPOSIT_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (dep_valid) begin
          amt_q   <= dep_amount;
          state_q <= CHECK;
        end
        CHECK: begin
          if (reject) begin
            st_q    <= 1'b0;
            state_q <= LOG;
          end else state_q <= CREDIT;
`ifdef DEPOSIT_TIMEOUT_EN
          cnt_q <= '0;
`endif
        end
        CREDIT: if (cash_inc_ack) begin
          st_q    <= 1'b1;
          state_q <= LOG;
        end
`ifdef DEPOSIT_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          st_q    <= 1'b0;
          state_q <= LOG;
        end else cnt_q <= cnt_q + 1'b1;
`endif
        LOG: begin
          dp_q    <= ~st_q;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_deposit_money_module.sv
// tb_deposit_money_module: scoreboard bench; expected log records are queued at request time and matched on log_valid.
module tb_deposit_money_module;
  logic       clock = 0;
  logic       reset_n = 0;
  logic       dep_valid = 0;
  logic [3:0] dep_amount = 0;
  logic       dep_ready;
  logic [7:0] cash_value = 0;
  logic       cash_inc_valid;
  logic [3:0] cash_inc_amount;
  logic       cash_inc_ack = 0;
  logic       log_valid;
  logic [1:0] log_op;
  logic       log_status;
  logic [3:0] log_amount;
  logic       done;
  logic       DP;
  int checks = 0;
  int errors = 0;
  int log_cnt = 0;
  logic [4:0] q[$];
  deposit_money_module dut (
    .clock(clock), .reset_n(reset_n), .dep_valid(dep_valid), .dep_amount(dep_amount),
    .dep_ready(dep_ready), .cash_value(cash_value), .cash_inc_valid(cash_inc_valid),
    .cash_inc_amount(cash_inc_amount), .cash_inc_ack(cash_inc_ack), .log_valid(log_valid),
    .log_op(log_op), .log_status(log_status), .log_amount(log_amount), .done(done), .DP(DP)
  );
  always #5 clock = ~clock;
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  always @(negedge clock) begin
    logic [4:0] r;
    if (reset_n && log_valid) begin
      log_cnt++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_log got status=%0d amount=%0d", log_status, log_amount);
      end else begin
        r = q.pop_front();
        if ({log_status, log_amount} !== r || log_op !== 2'b01 || done !== 1'b1) begin
          errors++;
          $display("FAIL log_record got status=%0d amount=%0d op=%0d done=%0d exp status=%0d amount=%0d op=1 done=1",
                   log_status, log_amount, log_op, done, r[4], r[3:0]);
        end
      end
    end
  end
  task automatic test_reset;
    #1;
    checks++;
    if (dep_ready !== 1 || cash_inc_valid !== 0 || cash_inc_amount !== 0 || log_valid !== 0 ||
        log_status !== 0 || log_amount !== 0 || done !== 0 || DP !== 0 || log_op !== 2'b01) begin
      errors++;
      $display("FAIL reset_state got rdy=%0d iv=%0d ia=%0d lv=%0d ls=%0d la=%0d done=%0d dp=%0d op=%0d exp 1 0 0 0 0 0 0 0 1",
               dep_ready, cash_inc_valid, cash_inc_amount, log_valid, log_status, log_amount, done, DP, log_op);
    end
    @(negedge clock);
    reset_n = 1;
  endtask
  task automatic run_credit(input logic [7:0] cash, input logic [3:0] amt, input int dly, input bit hold);
    cash_value = cash;
    q.push_back({1'b1, amt});
    @(negedge clock);
    dep_valid = 1; dep_amount = amt;
    checks++;
    if (dep_ready !== 1) begin errors++; $display("FAIL credit_idle_ready got %0d exp 1", dep_ready); end
    @(negedge clock);
    if (!hold) dep_valid = 0;
    checks++;
    if (dep_ready !== 0 || cash_inc_valid !== 0) begin
      errors++; $display("FAIL credit_check_cycle got rdy=%0d iv=%0d exp 0 0", dep_ready, cash_inc_valid);
    end
    for (int i = 0; i <= dly; i++) begin
      @(negedge clock);
      checks++;
      if (cash_inc_valid !== 1 || cash_inc_amount !== amt || dep_ready !== 0 || log_valid !== 0) begin
        errors++;
        $display("FAIL credit_wait cyc=%0d got iv=%0d ia=%0d rdy=%0d lv=%0d exp 1 %0d 0 0",
                 i, cash_inc_valid, cash_inc_amount, dep_ready, log_valid, amt);
      end
    end
    cash_inc_ack = 1;
    @(negedge clock);
    cash_inc_ack = 0; dep_valid = 0;
    checks++;
    if (log_valid !== 1 || cash_inc_valid !== 0) begin
      errors++; $display("FAIL credit_log_latency got lv=%0d iv=%0d exp 1 0", log_valid, cash_inc_valid);
    end
    @(negedge clock);
    checks++;
    if (DP !== 0 || dep_ready !== 1 || log_valid !== 0) begin
      errors++; $display("FAIL credit_after got dp=%0d rdy=%0d lv=%0d exp 0 1 0", DP, dep_ready, log_valid);
    end
  endtask
  task automatic run_reject(input logic [7:0] cash, input logic [3:0] amt);
    cash_value = cash;
    q.push_back({1'b0, amt});
    @(negedge clock);
    dep_valid = 1; dep_amount = amt;
    @(negedge clock);
    dep_valid = 0;
    checks++;
    if (cash_inc_valid !== 0 || log_valid !== 0) begin
      errors++; $display("FAIL reject_check_cycle got iv=%0d lv=%0d exp 0 0", cash_inc_valid, log_valid);
    end
    @(negedge clock);
    checks++;
    if (log_valid !== 1 || cash_inc_valid !== 0) begin
      errors++; $display("FAIL reject_log_latency got lv=%0d iv=%0d exp 1 0", log_valid, cash_inc_valid);
    end
    @(negedge clock);
    checks++;
    if (DP !== 1 || dep_ready !== 1) begin
      errors++; $display("FAIL reject_dp got dp=%0d rdy=%0d exp 1 1", DP, dep_ready);
    end
  endtask
  task automatic test_credit;
    run_credit(8'd100, 4'd5, 0, 0);
    run_credit(8'd250, 4'd5, 0, 0);
    run_credit(8'd0, 4'd15, 3, 0);
  endtask
  task automatic test_reject;
    run_reject(8'd251, 4'd5);
    run_reject(8'd255, 4'd1);
    run_reject(8'd10, 4'd0);
  endtask
  task automatic test_busy_ignored;
    int base;
    base = log_cnt;
    run_credit(8'd40, 4'd9, 6, 1);
    repeat (3) @(negedge clock);
    checks++;
    if (log_cnt - base !== 1 || cash_inc_valid !== 0 || dep_ready !== 1) begin
      errors++;
      $display("FAIL busy_single_log got logs=%0d iv=%0d rdy=%0d exp 1 0 1", log_cnt - base, cash_inc_valid, dep_ready);
    end
  endtask
  task automatic test_reset_mid;
    int base;
    run_reject(8'd250, 4'd9);
    base = log_cnt;
    cash_value = 8'd10;
    @(negedge clock);
    dep_valid = 1; dep_amount = 4'd7;
    @(negedge clock);
    dep_valid = 0;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (cash_inc_valid !== 1) begin errors++; $display("FAIL midreset_precredit got iv=%0d exp 1", cash_inc_valid); end
    #2 reset_n = 0;
    #1;
    checks++;
    if (cash_inc_valid !== 0 || dep_ready !== 1 || DP !== 0 || log_valid !== 0 || done !== 0 ||
        cash_inc_amount !== 0 || log_amount !== 0 || log_status !== 0) begin
      errors++;
      $display("FAIL midreset_outputs got iv=%0d rdy=%0d dp=%0d lv=%0d done=%0d ia=%0d la=%0d ls=%0d exp 0 1 0 0 0 0 0 0",
               cash_inc_valid, dep_ready, DP, log_valid, done, cash_inc_amount, log_amount, log_status);
    end
    @(negedge clock);
    reset_n = 1;
    repeat (3) @(negedge clock);
    checks++;
    if (log_cnt !== base || cash_inc_valid !== 0) begin
      errors++; $display("FAIL midreset_nolog got logs=%0d iv=%0d exp %0d 0", log_cnt, cash_inc_valid, base);
    end
    run_credit(8'd20, 4'd3, 2, 0);
  endtask
`ifdef DEPOSIT_TIMEOUT_EN
  task automatic test_timeout;
    cash_value = 8'd30;
    q.push_back({1'b0, 4'd6});
    @(negedge clock);
    dep_valid = 1; dep_amount = 4'd6;
    @(negedge clock);
    dep_valid = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      checks++;
      if (cash_inc_valid !== 1) begin errors++; $display("FAIL timeout_wait cyc=%0d got iv=%0d exp 1", i, cash_inc_valid); end
    end
    @(negedge clock);
    checks++;
    if (cash_inc_valid !== 0 || log_valid !== 1) begin
      errors++; $display("FAIL timeout_expire got iv=%0d lv=%0d exp 0 1", cash_inc_valid, log_valid);
    end
    @(negedge clock);
    checks++;
    if (DP !== 1) begin errors++; $display("FAIL timeout_dp got %0d exp 1", DP); end
  endtask
`endif
  initial begin
    test_reset();
    test_credit();
    test_reject();
    test_busy_ignored();
    test_reset_mid();
`ifdef DEPOSIT_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) @(negedge clock);
    checks++;
    if (q.size() !== 0) begin errors++; $display("FAIL scoreboard_drain got %0d pending exp 0", q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
